seven_segment_mux_controller: RTL and testbench

SEVEN_SEGMENT_MUX_CONTROLLER -- requirements
Module: seven_segment_mux_controller

---
 rtl/seven_segment_pkg.sv | 14 +
 rtl/seven_segment_display.sv | 30 +++
 rtl/seven_segment_mux_controller.sv | 102 ++++++++++
 tb/tb_seven_segment_mux_controller.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// Shared types and constants for the two-digit multiplexed seven-segment display.
package seven_segment_pkg;

  typedef enum logic [1:0] {
    BLANK0 = 2'd0,
    SHOW0  = 2'd1,
    BLANK1 = 2'd2,
    SHOW1  = 2'd3
  } mux_state_t;

  localparam logic [6:0] SEG_OFF   = 7'b1111111;
  localparam logic [1:0] ANODE_OFF = 2'b11;

endpackage

// File: rtl/seven_segment_display.sv
// Hex value to active-low seven-segment glyph, segments ordered {g,f,e,d,c,b,a}.
module seven_segment_display (
  input  logic [3:0] value,
  output logic [6:0] segments
);

  always_comb begin
    segments = 7'b1111111;
    case (value)
      4'h0: segments = 7'b1000000;
      4'h1: segments = 7'b1111001;
      4'h2: segments = 7'b0100100;
      4'h3: segments = 7'b0110000;
      4'h4: segments = 7'b0011001;
      4'h5: segments = 7'b0010010;
      4'h6: segments = 7'b0000010;
      4'h7: segments = 7'b1111000;
      4'h8: segments = 7'b0000000;
      4'h9: segments = 7'b0010000;
      4'hA: segments = 7'b0001000;
      4'hB: segments = 7'b0000011;
      4'hC: segments = 7'b1000110;
      4'hD: segments = 7'b0100001;
      4'hE: segments = 7'b0000110;
      4'hF: segments = 7'b0001110;
      default: segments = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/seven_segment_mux_controller.sv
// Two-digit time-multiplexed seven-segment driver with blanking gaps between digits.
// Optional build macro SEVSEG_LEADING_ZERO_BLANK_EN blanks digit 1 when it is zero.
module seven_segment_mux_controller
  import seven_segment_pkg::*;
#(
  parameter int SHOW_CYCLES  = 24000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  output logic [6:0] segments,
  output logic [1:0] anode,
  output logic       frame_done
);

  localparam int MAX_DWELL = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int CNT_W     = $clog2(MAX_DWELL) + 1;
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  mux_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       digit0_q, digit1_q;
  logic             fresh, fresh_n;
  logic             latch_digits;
  logic [3:0]       dec_value;
  logic [6:0]       dec_segments;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= BLANK0;
      cnt      <= '0;
      digit0_q <= 4'h0;
      digit1_q <= 4'h0;
      fresh    <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      fresh <= fresh_n;
      if (latch_digits) begin
        digit0_q <= digit0;
        digit1_q <= digit1;
      end
    end
  end

  // Frame sequencing; a restart after reset or disable latches on its first enabled edge.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt + 1'b1;
    latch_digits = fresh;
    fresh_n      = 1'b0;
    case (state)
      BLANK0: if (cnt == BLANK_LAST) begin state_n = SHOW0;  cnt_n = '0; end
      SHOW0:  if (cnt == SHOW_LAST)  begin state_n = BLANK1; cnt_n = '0; end
      BLANK1: if (cnt == BLANK_LAST) begin state_n = SHOW1;  cnt_n = '0; end
      SHOW1:  if (cnt == SHOW_LAST) begin
        state_n      = BLANK0;
        cnt_n        = '0;
        latch_digits = 1'b1;
      end
      default: begin state_n = BLANK0; cnt_n = '0; end
    endcase
    if (!enable) begin
      state_n      = BLANK0;
      cnt_n        = '0;
      latch_digits = 1'b0;
      fresh_n      = 1'b1;
    end
  end

  assign dec_value = (state == SHOW1) ? digit1_q : digit0_q;

  seven_segment_display u_decoder (
    .value    (dec_value),
    .segments (dec_segments)
  );

  always_comb begin
    anode      = ANODE_OFF;
    segments   = SEG_OFF;
    frame_done = (state == SHOW1) && (cnt == SHOW_LAST);
    if (state == SHOW0) begin
      anode    = 2'b10;
      segments = dec_segments;
    end else if (state == SHOW1) begin
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
      if (digit1_q != 4'h0) begin
        anode    = 2'b01;
        segments = dec_segments;
      end
`else
      anode    = 2'b01;
      segments = dec_segments;
`endif
    end
  end

endmodule

// File: tb/tb_seven_segment_mux_controller.sv
// Scoreboard bench: a frame-position model predicts every cycle; a monitor compares at negedge.
module tb_seven_segment_mux_controller;

  localparam int SHOW   = 4;
  localparam int BLANK  = 2;
  localparam int PERIOD = 2 * (SHOW + BLANK);

  typedef struct packed {
    logic [1:0] anode;
    logic [6:0] segments;
    logic       frame_done;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [6:0] segments;
  logic [1:0] anode;
  logic       frame_done;

  obs_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  int         pos   = 0;
  bit         fresh = 1'b1;
  logic [3:0] m_d0  = 4'h0;
  logic [3:0] m_d1  = 4'h0;

  // Active-high {g..a} glyphs; the display drives the inverse.
  logic [6:0] glyph_hi [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seven_segment_mux_controller #(.SHOW_CYCLES(SHOW), .BLANK_CYCLES(BLANK)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .digit0     (digit0),
    .digit1     (digit1),
    .segments   (segments),
    .anode      (anode),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic obs_t predict(int p, logic [3:0] d0, logic [3:0] d1);
    obs_t e;
    e.anode      = 2'b11;
    e.segments   = 7'b1111111;
    e.frame_done = (p == PERIOD - 1);
    if (p >= BLANK && p < BLANK + SHOW) begin
      e.anode    = 2'b10;
      e.segments = ~glyph_hi[d0];
    end else if (p >= 2 * BLANK + SHOW) begin
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
      if (d1 != 4'h0) begin
        e.anode    = 2'b01;
        e.segments = ~glyph_hi[d1];
      end
`else
      e.anode    = 2'b01;
      e.segments = ~glyph_hi[d1];
`endif
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic r, input logic en, input logic [3:0] d0, input logic [3:0] d1);
    @(negedge clk);
    reset  = r;
    enable = en;
    digit0 = d0;
    digit1 = d1;
    @(posedge clk);
    if (!r) begin
      pos = 0; fresh = 1'b1; m_d0 = 4'h0; m_d1 = 4'h0;
    end else if (!en) begin
      pos = 0; fresh = 1'b1;
    end else begin
      if ((pos == 0 && fresh) || pos == PERIOD - 1) begin
        m_d0 = d0;
        m_d1 = d1;
      end
      fresh = 1'b0;
      pos   = (pos + 1) % PERIOD;
    end
    exp_q.push_back(predict(pos, m_d0, m_d1));
  endtask

  task automatic checkOutput(input obs_t e);
    obs_t a;
    a = '{anode: anode, segments: segments, frame_done: frame_done};
    checks++;
    if (a === e && anode !== 2'b00) begin
      passes++;
    end else begin
      $display("[TB] FAIL outputs at %0t: actual anode=%b seg=%b fd=%b, required anode=%b seg=%b fd=%b",
               $time, a.anode, a.segments, a.frame_done, e.anode, e.segments, e.frame_done);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  initial begin
    logic [3:0] d0, d1;
    logic       en, r;
    reset  = 1'b0;
    enable = 1'b1;
    digit0 = 4'h3;
    digit1 = 4'hA;

    repeat (2) applyStimulus(1'b0, 1'b1, 4'h3, 4'hA);
    repeat (3 * PERIOD) applyStimulus(1'b1, 1'b1, 4'h3, 4'hA);

    // Digit change in SHOW1 shows next frame; change in SHOW0 waits a frame.
    repeat (PERIOD - 3) applyStimulus(1'b1, 1'b1, 4'h3, 4'hA);
    repeat (PERIOD + 6) applyStimulus(1'b1, 1'b1, 4'h7, 4'hA);
    repeat (2 * PERIOD) applyStimulus(1'b1, 1'b1, 4'h3, 4'hA);

    repeat (5) applyStimulus(1'b1, 1'b0, 4'h3, 4'hA);
    repeat (2 * PERIOD) applyStimulus(1'b1, 1'b1, 4'h3, 4'hA);

    repeat (9) applyStimulus(1'b1, 1'b1, 4'h3, 4'hA);
    applyStimulus(1'b0, 1'b1, 4'h3, 4'hA);
    repeat (2 * PERIOD) applyStimulus(1'b1, 1'b1, 4'h3, 4'h0);

    for (int v = 0; v < 16; v++) begin
      repeat (PERIOD) applyStimulus(1'b1, 1'b1, 4'(v), 4'h5);
    end

    d0 = 4'h1;
    d1 = 4'h2;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 4) == 0) d0 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) d1 = 4'($urandom_range(0, 15));
      en = ($urandom_range(0, 19) != 0);
      r  = ($urandom_range(0, 49) != 0);
      applyStimulus(r, en, d0, d1);
    end

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      $display("[TB] FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
